// File: rtl/accumulator16.sv
// accumulator16: 16-bit accumulator with a valid/ready handshake on both sides.
// Ports: CLK, Reset (sync, active-high); Din/OP/InValid/InReady operand side;
//        AccOut/OutValid/OutReady result side; Zero/Carry/Overflow flags.
module accumulator16 (
    input  logic        CLK,
    input  logic        Reset,
    input  logic [15:0] Din,
    input  logic [2:0]  OP,
    input  logic        InValid,
    output logic        InReady,
    output logic [15:0] AccOut,
    output logic        OutValid,
    input  logic        OutReady,
    output logic        Zero,
    output logic        Carry,
    output logic        Overflow
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [2:0] OP_LOAD = 3'b000;
    localparam logic [2:0] OP_ADD  = 3'b001;
    localparam logic [2:0] OP_SUB  = 3'b010;
    localparam logic [2:0] OP_AND  = 3'b011;
    localparam logic [2:0] OP_OR   = 3'b100;
    localparam logic [2:0] OP_XOR  = 3'b101;
    localparam logic [2:0] OP_SHL  = 3'b110;
    localparam logic [2:0] OP_CLR  = 3'b111;

    state_t      state_q, state_d;
    logic [15:0] din_q;
    logic [2:0]  op_q;
    logic [15:0] acc_q, acc_d;
    logic        zero_q, carry_q, ovf_q;
    logic        carry_d, ovf_d;
    logic [16:0] wide;

    // Next-state logic; handshakes only move the FSM in their own state.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (InValid)  state_d = EXEC;
            EXEC:                  state_d = HOLD;
            HOLD:    if (OutReady) state_d = IDLE;
            default:               state_d = IDLE;
        endcase
    end

    // Datapath: result and flags of the captured operation.
    always_comb begin
        acc_d   = acc_q;
        carry_d = 1'b0;
        ovf_d   = 1'b0;
        wide    = 17'd0;
        unique case (op_q)
            OP_LOAD: acc_d = din_q;
            OP_ADD: begin
                wide    = {1'b0, acc_q} + {1'b0, din_q};
                acc_d   = wide[15:0];
                carry_d = wide[16];
                ovf_d   = (acc_q[15] == din_q[15]) &&
                          (wide[15] != acc_q[15]);
            end
            OP_SUB: begin
                // Bit 16 of the 17-bit difference is the unsigned borrow.
                wide    = {1'b0, acc_q} - {1'b0, din_q};
                acc_d   = wide[15:0];
                carry_d = wide[16];
                ovf_d   = (acc_q[15] != din_q[15]) &&
                          (wide[15] != acc_q[15]);
            end
            OP_AND:  acc_d = acc_q & din_q;
            OP_OR:   acc_d = acc_q | din_q;
            OP_XOR:  acc_d = acc_q ^ din_q;
            OP_SHL: begin
                acc_d   = {acc_q[14:0], 1'b0};
                carry_d = acc_q[15];
            end
            OP_CLR:  acc_d = 16'h0000;
            default: acc_d = acc_q;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q <= IDLE;
            din_q   <= 16'h0000;
            op_q    <= 3'b000;
            acc_q   <= 16'h0000;
            zero_q  <= 1'b1;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && InValid) begin
                din_q <= Din;
                op_q  <= OP;
            end
            if (state_q == EXEC) begin
                acc_q   <= acc_d;
                zero_q  <= (acc_d == 16'h0000);
                carry_q <= carry_d;
                ovf_q   <= ovf_d;
            end
        end
    end

    assign InReady  = (state_q == IDLE);
    assign OutValid = (state_q == HOLD);
    assign AccOut   = acc_q;
    assign Zero     = zero_q;
    assign Carry    = carry_q;
    assign Overflow = ovf_q;

endmodule

// File: tb/tb_accumulator16.sv
// tb_accumulator16: directed table-driven bench for accumulator16.
// Checks reset state, every opcode, flags, HOLD stall and reset abort.
module tb_accumulator16;

    logic        CLK = 1'b0;
    logic        Reset;
    logic [15:0] Din;
    logic [2:0]  OP;
    logic        InValid;
    logic        InReady;
    logic [15:0] AccOut;
    logic        OutValid;
    logic        OutReady;
    logic        Zero, Carry, Overflow;

    int total = 0;
    int bad   = 0;

    accumulator16 dut (
        .CLK      (CLK),
        .Reset    (Reset),
        .Din      (Din),
        .OP       (OP),
        .InValid  (InValid),
        .InReady  (InReady),
        .AccOut   (AccOut),
        .OutValid (OutValid),
        .OutReady (OutReady),
        .Zero     (Zero),
        .Carry    (Carry),
        .Overflow (Overflow)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [15:0] din;
        logic [15:0] acc;
        logic        z;
        logic        c;
        logic        v;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string name, input logic [15:0] act,
                       input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_ready(input string name);
        int n;
        n = 0;
        while (InReady !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        chk({name, " ready timeout"}, 16'(InReady), 16'd1);
    endtask

    // Full transaction: accept, one EXEC cycle, then result in HOLD.
    task automatic run_vec(input vec_t v);
        wait_ready(v.name);
        OP      = v.op;
        Din     = v.din;
        InValid = 1'b1;
        step();
        InValid = 1'b0;
        Din     = 16'hDEAD;
        chk({v.name, " exec InReady"}, 16'(InReady), 16'd0);
        chk({v.name, " exec OutValid"}, 16'(OutValid), 16'd0);
        step();
        chk({v.name, " OutValid"}, 16'(OutValid), 16'd1);
        chk({v.name, " AccOut"}, AccOut, v.acc);
        chk({v.name, " flags"}, {13'd0, Zero, Carry, Overflow},
            {13'd0, v.z, v.c, v.v});
        OutReady = 1'b1;
        step();
        OutReady = 1'b0;
        chk({v.name, " back idle"}, 16'(InReady), 16'd1);
    endtask

    initial begin
        vecs[0]  = '{"load1234", 3'b000, 16'h1234, 16'h1234, 0, 0, 0};
        vecs[1]  = '{"loadFFFF", 3'b000, 16'hFFFF, 16'hFFFF, 0, 0, 0};
        vecs[2]  = '{"addwrap",  3'b001, 16'h0001, 16'h0000, 1, 1, 0};
        vecs[3]  = '{"load7FFF", 3'b000, 16'h7FFF, 16'h7FFF, 0, 0, 0};
        vecs[4]  = '{"addovf",   3'b001, 16'h0001, 16'h8000, 0, 0, 1};
        vecs[5]  = '{"subborrow",3'b010, 16'h8001, 16'hFFFF, 0, 1, 0};
        vecs[6]  = '{"load8001", 3'b000, 16'h8001, 16'h8001, 0, 0, 0};
        vecs[7]  = '{"shl1",     3'b110, 16'h5555, 16'h0002, 0, 1, 0};
        vecs[8]  = '{"clr",      3'b111, 16'h1234, 16'h0000, 1, 0, 0};
        vecs[9]  = '{"load00F0", 3'b000, 16'h00F0, 16'h00F0, 0, 0, 0};
        vecs[10] = '{"and",      3'b011, 16'h0F3C, 16'h0030, 0, 0, 0};
        vecs[11] = '{"or",       3'b100, 16'h0F00, 16'h0F30, 0, 0, 0};
        vecs[12] = '{"xor",      3'b101, 16'hFFFF, 16'hF0CF, 0, 0, 0};
        vecs[13] = '{"subzero",  3'b010, 16'hF0CF, 16'h0000, 1, 0, 0};
        vecs[14] = '{"load8000", 3'b000, 16'h8000, 16'h8000, 0, 0, 0};
        vecs[15] = '{"subovf",   3'b010, 16'h0001, 16'h7FFF, 0, 0, 1};

        Reset    = 1'b1;
        Din      = 16'h0000;
        OP       = 3'b000;
        InValid  = 1'b0;
        OutReady = 1'b0;
        step();
        step();
        Reset = 1'b0;
        step();
        chk("rst InReady", 16'(InReady), 16'd1);
        chk("rst OutValid", 16'(OutValid), 16'd0);
        chk("rst AccOut", AccOut, 16'h0000);
        chk("rst flags", {13'd0, Zero, Carry, Overflow}, 16'b100);

        for (int i = 0; i < 16; i++) run_vec(vecs[i]);

        // SHL1 of 0x7FFF: shifted-out bit is 0.
        run_vec('{"shlnc", 3'b110, 16'h0000, 16'hFFFE, 0, 0, 0});

        // Stall in HOLD while upstream wiggles InValid/Din.
        run_vec('{"load00AA", 3'b000, 16'h00AA, 16'h00AA, 0, 0, 0});
        wait_ready("stall");
        OP      = 3'b001;
        Din     = 16'h0011;
        InValid = 1'b1;
        step();
        InValid = 1'b0;
        step();
        chk("stall enter", 16'(OutValid), 16'd1);
        for (int i = 0; i < 5; i++) begin
            InValid = i[0];
            Din     = 16'(i * 16'h1111);
            OP      = 3'b111;
            step();
            chk("stall InReady", 16'(InReady), 16'd0);
            chk("stall OutValid", 16'(OutValid), 16'd1);
            chk("stall AccOut", AccOut, 16'h00BB);
            chk("stall flags", {13'd0, Zero, Carry, Overflow}, 16'd0);
        end

        // OutReady and InValid together in HOLD: leave without accepting.
        OP       = 3'b000;
        Din      = 16'h4321;
        InValid  = 1'b1;
        OutReady = 1'b1;
        step();
        OutReady = 1'b0;
        chk("same-edge idle", 16'(InReady), 16'd1);
        chk("same-edge noacc", 16'(OutValid), 16'd0);
        step();
        InValid = 1'b0;
        chk("late accept", 16'(InReady), 16'd0);
        step();
        chk("late result", AccOut, 16'h4321);
        OutReady = 1'b1;
        step();
        OutReady = 1'b0;

        // Reset during EXEC discards the pending ADD.
        run_vec('{"load0010", 3'b000, 16'h0010, 16'h0010, 0, 0, 0});
        wait_ready("abort");
        OP      = 3'b001;
        Din     = 16'h0005;
        InValid = 1'b1;
        step();
        InValid = 1'b0;
        Reset   = 1'b1;
        OutReady = 1'b1;
        step();
        Reset    = 1'b0;
        OutReady = 1'b0;
        chk("abort InReady", 16'(InReady), 16'd1);
        chk("abort OutValid", 16'(OutValid), 16'd0);
        chk("abort AccOut", AccOut, 16'h0000);
        chk("abort Zero", 16'(Zero), 16'd1);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("abort never", 16'(AccOut == 16'h0015), 16'd0);
            chk("abort idle", 16'(OutValid), 16'd0);
        end

        // Reset wins over InValid in IDLE and aborts HOLD.
        Reset   = 1'b1;
        InValid = 1'b1;
        Din     = 16'h7777;
        step();
        Reset   = 1'b0;
        InValid = 1'b0;
        chk("rst prio idle", 16'(InReady), 16'd1);
        run_vec('{"load0F0F", 3'b000, 16'h0F0F, 16'h0F0F, 0, 0, 0});
        wait_ready("rsthold");
        OP      = 3'b001;
        Din     = 16'h0001;
        InValid = 1'b1;
        step();
        InValid = 1'b0;
        step();
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        chk("rst hold OutValid", 16'(OutValid), 16'd0);
        chk("rst hold AccOut", AccOut, 16'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
